// File: rtl/mem_stage_lsu.sv
// Memory-stage load/store unit. Decodes the X/M instruction, drives a
// single-outstanding req/ack data bus, stalls the pipeline while the access
// is in flight, and returns the aligned, extended load data (or the ALU
// result) to the M/W latch. All state changes on the falling clock edge.
// Optional feature: define LSU_TIMEOUT_EN to abort a request after
// TIMEOUT_CYCLES unacknowledged REQ cycles and report it on o_bus_err.
module mem_stage_lsu #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] i_insn,
    input  logic [31:0] i_ALU_O,
    input  logic [31:0] i_regfile_B,
    output logic        o_mem_req,
    output logic        o_mem_we,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    output logic [3:0]  o_mem_wstrb,
    input  logic        i_mem_ack,
    input  logic [31:0] i_mem_rdata,
    output logic [31:0] o_result,
    output logic        o_stall,
`ifdef LSU_TIMEOUT_EN
    output logic        o_bus_err,
`endif
    output logic        o_misaligned
);

    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_DONE
    } state_t;

    state_t      state_q, state_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic [31:0] result_q, result_d;

    logic [2:0]  funct3;
    logic        is_load, is_store, is_mem, misaligned, mem_go;
    logic [31:0] st_wdata;
    logic [3:0]  st_wstrb;

`ifdef LSU_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             bus_err_q, bus_err_d;
    assign o_bus_err = bus_err_q;
`endif

    // Only opcode and funct3 matter here; the rest of the word is ignored.
    logic unused_ok;
    assign unused_ok = ^{i_insn[31:15], i_insn[11:7], 32'(TIMEOUT_CYCLES)};

    assign funct3 = i_insn[14:12];

    // Pull the addressed byte/half out of the read word and extend it.
    function automatic logic [31:0] load_extract(input logic [2:0]  f3,
                                                 input logic [1:0]  lane,
                                                 input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{lane, 3'b000} +: 8];
        h = lane[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  return {{24{b[7]}}, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b100:  return {24'h0, b};
            3'b101:  return {16'h0, h};
            default: return word;
        endcase
    endfunction

    // Classify the instruction and check natural alignment of the access.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned, which would infer a latch.
        is_load    = 1'b0;
        is_store   = 1'b0;
        misaligned = 1'b0;
        if (i_insn[6:0] == OPC_LOAD)
            is_load = funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        if (i_insn[6:0] == OPC_STORE)
            is_store = funct3 inside {3'b000, 3'b001, 3'b010};
        is_mem = is_load | is_store;
        if (is_mem) begin
            case (funct3[1:0])
                2'b01:   misaligned = i_ALU_O[0];
                2'b10:   misaligned = |i_ALU_O[1:0];
                default: misaligned = 1'b0;
            endcase
        end
        mem_go = is_mem & ~misaligned;
    end

    // Replicate store data across lanes and build the byte enables.
    always_comb begin
        st_wdata = i_regfile_B;
        st_wstrb = 4'b1111;
        case (funct3[1:0])
            2'b00: begin
                st_wdata = {4{i_regfile_B[7:0]}};
                st_wstrb = 4'b0001 << i_ALU_O[1:0];
            end
            2'b01: begin
                st_wdata = {2{i_regfile_B[15:0]}};
                st_wstrb = i_ALU_O[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                st_wdata = i_regfile_B;
                st_wstrb = 4'b1111;
            end
        endcase
    end

    // Next-state logic: issue in IDLE, wait for ack (or timeout) in REQ,
    // present the result for one cycle in DONE.
    always_comb begin
        state_d  = state_q;
        req_d    = req_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        wstrb_d  = wstrb_q;
        result_d = result_q;
`ifdef LSU_TIMEOUT_EN
        cnt_d     = cnt_q;
        bus_err_d = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (mem_go) begin
                    state_d = ST_REQ;
                    req_d   = 1'b1;
                    we_d    = is_store;
                    addr_d  = {i_ALU_O[31:2], 2'b00};
                    wdata_d = is_store ? st_wdata : 32'h0;
                    wstrb_d = is_store ? st_wstrb : 4'b0000;
`ifdef LSU_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            ST_REQ: begin
                if (i_mem_ack) begin
                    state_d  = ST_DONE;
                    req_d    = 1'b0;
                    result_d = is_store ? i_ALU_O
                                        : load_extract(funct3, i_ALU_O[1:0], i_mem_rdata);
                end
`ifdef LSU_TIMEOUT_EN
                else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_d == CNT_W'(TIMEOUT_CYCLES)) begin
                        state_d   = ST_DONE;
                        req_d     = 1'b0;
                        result_d  = 32'h0;
                        bus_err_d = 1'b1;
                    end
                end
`endif
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and bus registers, updated with the pipeline latches.
    always_ff @(negedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= 32'h0;
            wdata_q  <= 32'h0;
            wstrb_q  <= 4'b0000;
            result_q <= 32'h0;
`ifdef LSU_TIMEOUT_EN
            cnt_q     <= '0;
            bus_err_q <= 1'b0;
`endif
        end else begin
            // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
            state_q  <= state_d;
            req_q    <= req_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            wstrb_q  <= wstrb_d;
            result_q <= result_d;
`ifdef LSU_TIMEOUT_EN
            cnt_q     <= cnt_d;
            bus_err_q <= bus_err_d;
`endif
        end
    end

    assign o_mem_req    = req_q;
    assign o_mem_we     = we_q;
    assign o_mem_addr   = addr_q;
    assign o_mem_wdata  = wdata_q;
    assign o_mem_wstrb  = wstrb_q;
    assign o_misaligned = misaligned;
    assign o_stall      = mem_go && (state_q != ST_DONE);

    // Result mux: misaligned forces zero, memory ops use the captured value.
    always_comb begin
        if (misaligned)  o_result = 32'h0;
        else if (mem_go) o_result = result_q;
        else             o_result = i_ALU_O;
    end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Self-checking bench for mem_stage_lsu: directed cases plus random
// instructions, checked every cycle against a transaction-level model.
`timescale 1ns/1ps
module tb_mem_stage_lsu;

    localparam int TO = 4;
`ifdef LSU_TIMEOUT_EN
    localparam int MAXD = TO - 1;
`else
    localparam int MAXD = 6;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] i_insn, i_ALU_O, i_regfile_B, i_mem_rdata;
    logic        i_mem_ack;
    logic        o_mem_req, o_mem_we, o_stall, o_misaligned;
    logic [31:0] o_mem_addr, o_mem_wdata, o_result;
    logic [3:0]  o_mem_wstrb;
    logic        bus_err;

    always #5 clock = ~clock;

    mem_stage_lsu #(.TIMEOUT_CYCLES(TO)) dut (
        .clock       (clock),
        .reset       (reset),
        .i_insn      (i_insn),
        .i_ALU_O     (i_ALU_O),
        .i_regfile_B (i_regfile_B),
        .o_mem_req   (o_mem_req),
        .o_mem_we    (o_mem_we),
        .o_mem_addr  (o_mem_addr),
        .o_mem_wdata (o_mem_wdata),
        .o_mem_wstrb (o_mem_wstrb),
        .i_mem_ack   (i_mem_ack),
        .i_mem_rdata (i_mem_rdata),
        .o_result    (o_result),
        .o_stall     (o_stall),
`ifdef LSU_TIMEOUT_EN
        .o_bus_err   (bus_err),
`endif
        .o_misaligned(o_misaligned)
    );
`ifndef LSU_TIMEOUT_EN
    assign bus_err = 1'b0;
`endif

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Phase of the current instruction as seen from the bus protocol.
    typedef enum {PH_OFF, PH_COMB, PH_IDLE, PH_REQ, PH_DONE} phase_t;
    phase_t phase = PH_OFF;

    // Model expectations for the instruction currently presented.
    logic        exp_mem, exp_mis, exp_we, exp_err;
    logic [31:0] exp_result, exp_addr, exp_wdata;
    logic [3:0]  exp_wstrb;
    // Hand-computed literals pinned on directed cases.
    logic        pin_res_en = 0, pin_bus_en = 0, pin_wd_en = 0;
    logic [31:0] pin_res, pin_addr, pin_wdata;
    logic [3:0]  pin_wstrb;

    // Behavioural model: derive every expected output from the instruction rules.
    task automatic model_set(input logic [31:0] insn, addr, b, rdata, input logic timeout);
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic        ld, st;
        int          nbytes, off;
        logic [31:0] mask, v;
        opc    = insn[6:0];
        f3     = insn[14:12];
        ld     = (opc == 7'h03) && (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        st     = (opc == 7'h23) && (f3 inside {3'd0, 3'd1, 3'd2});
        nbytes = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        off    = int'(addr % 4);
        exp_mem = 0; exp_mis = 0; exp_we = 0; exp_err = 0;
        exp_addr = 0; exp_wdata = 0; exp_wstrb = 0;
        if (!(ld || st)) begin
            exp_result = addr;
        end else if ((addr % nbytes) != 0) begin
            exp_mis    = 1;
            exp_result = 32'h0;
        end else begin
            exp_mem  = 1;
            exp_we   = st;
            exp_addr = addr - (addr % 4);
            if (st) begin
                exp_wstrb  = 4'(((1 << nbytes) - 1) << off);
                exp_wdata  = (nbytes == 1) ? b[7:0] * 32'h01010101 :
                             (nbytes == 2) ? b[15:0] * 32'h00010001 : b;
                exp_result = addr;
            end else begin
                mask = (nbytes == 4) ? 32'hFFFFFFFF : (32'd1 << (8 * nbytes)) - 32'd1;
                v    = (rdata >> (8 * off)) & mask;
                if (!f3[2] && nbytes < 4 && v[8 * nbytes - 1]) v = v | ~mask;
                exp_result = v;
            end
            if (timeout) begin
                exp_result = 32'h0;
                exp_err    = 1;
            end
        end
    endtask

    // Compare process: check the DUT on every rising edge, away from the active falling edge.
    always @(posedge clock) begin
        if (!reset) begin
            if (phase != PH_OFF)
                check("bus_err", {31'h0, bus_err}, (phase == PH_DONE) ? {31'h0, exp_err} : 32'h0);
            case (phase)
                PH_COMB: begin
                    check("comb_stall", {31'h0, o_stall}, 32'h0);
                    check("comb_req", {31'h0, o_mem_req}, 32'h0);
                    check("comb_misaligned", {31'h0, o_misaligned}, {31'h0, exp_mis});
                    check("comb_result", o_result, exp_result);
                    if (pin_res_en) check("comb_result_literal", o_result, pin_res);
                end
                PH_IDLE: begin
                    check("idle_stall", {31'h0, o_stall}, 32'h1);
                    check("idle_req", {31'h0, o_mem_req}, 32'h0);
                    check("idle_misaligned", {31'h0, o_misaligned}, 32'h0);
                end
                PH_REQ: begin
                    check("req_stall", {31'h0, o_stall}, 32'h1);
                    check("req_req", {31'h0, o_mem_req}, 32'h1);
                    check("req_we", {31'h0, o_mem_we}, {31'h0, exp_we});
                    check("req_addr", o_mem_addr, exp_addr);
                    check("req_wstrb", {28'h0, o_mem_wstrb}, {28'h0, exp_wstrb});
                    if (exp_we) check("req_wdata", o_mem_wdata, exp_wdata);
                    if (pin_bus_en) begin
                        check("req_addr_literal", o_mem_addr, pin_addr);
                        check("req_wstrb_literal", {28'h0, o_mem_wstrb}, {28'h0, pin_wstrb});
                    end
                    if (pin_wd_en) check("req_wdata_literal", o_mem_wdata, pin_wdata);
                end
                PH_DONE: begin
                    check("done_stall", {31'h0, o_stall}, 32'h0);
                    check("done_req", {31'h0, o_mem_req}, 32'h0);
                    check("done_result", o_result, exp_result);
                    if (pin_res_en) check("done_result_literal", o_result, pin_res);
                end
                default: ;
            endcase
        end
    end

    // Present one instruction and play the bus side; delay<0 means never ack.
    task automatic run_op(input logic [31:0] insn, addr, b, rdata, input int delay);
        model_set(insn, addr, b, rdata, delay < 0);
        i_insn      = insn;
        i_ALU_O     = addr;
        i_regfile_B = b;
        i_mem_ack   = 1'($urandom_range(0, 1));   // ignored outside REQ
        i_mem_rdata = $urandom;
        if (!exp_mem) begin
            phase = PH_COMB;
            @(negedge clock); #1;
        end else begin
            phase = PH_IDLE;
            @(negedge clock); #1;
            phase     = PH_REQ;
            i_mem_ack = 0;
            if (delay < 0) begin
                repeat (TO) begin @(negedge clock); #1; end
            end else begin
                repeat (delay) begin @(negedge clock); #1; end
                i_mem_ack   = 1;
                i_mem_rdata = rdata;
                @(negedge clock); #1;
            end
            phase       = PH_DONE;
            i_mem_ack   = 1'($urandom_range(0, 1));
            i_mem_rdata = $urandom;
            @(negedge clock); #1;
        end
        phase      = PH_OFF;
        i_mem_ack  = 0;
        pin_res_en = 0;
        pin_bus_en = 0;
        pin_wd_en  = 0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] insn;
        int          sel;

        reset = 1; i_insn = 32'h0; i_ALU_O = 32'h77; i_regfile_B = 0;
        i_mem_ack = 0; i_mem_rdata = 0;
        #1;
        check("rst_req", {31'h0, o_mem_req}, 32'h0);
        check("rst_we", {31'h0, o_mem_we}, 32'h0);
        check("rst_addr", o_mem_addr, 32'h0);
        check("rst_wdata", o_mem_wdata, 32'h0);
        check("rst_wstrb", {28'h0, o_mem_wstrb}, 32'h0);
        check("rst_stall", {31'h0, o_stall}, 32'h0);
        check("rst_result", o_result, 32'h77);
        @(negedge clock); #1;
        @(negedge clock); #1;
        reset = 0;

        // Non-memory instruction passes the ALU result straight through.
        pin_res_en = 1; pin_res = 32'h1234;
        run_op(32'h00B50533, 32'h1234, 32'h0, 32'h0, 0);
        // LW, ack on the first REQ edge.
        pin_res_en = 1; pin_res = 32'hDEADBEEF;
        pin_bus_en = 1; pin_addr = 32'h100; pin_wstrb = 4'b0000;
        run_op(32'h0002A303, 32'h100, 32'h0, 32'hDEADBEEF, 0);
        // LB / LBU on the top byte lane.
        pin_res_en = 1; pin_res = 32'hFFFFFF80;
        run_op(32'h00028303, 32'h103, 32'h0, 32'h80FFFFFF, 1);
        pin_res_en = 1; pin_res = 32'h00000080;
        run_op(32'h0002C303, 32'h103, 32'h0, 32'h80FFFFFF, 2);
        // SB / SH to address 0x202.
        pin_bus_en = 1; pin_addr = 32'h200; pin_wstrb = 4'b0100;
        pin_wd_en = 1; pin_wdata = 32'hABABABAB; pin_res_en = 1; pin_res = 32'h202;
        run_op(32'h00628023, 32'h202, 32'h000000AB, 32'h0, 0);
        pin_bus_en = 1; pin_addr = 32'h200; pin_wstrb = 4'b1100;
        pin_wd_en = 1; pin_wdata = 32'h00AB00AB;
        run_op(32'h00629023, 32'h202, 32'h000000AB, 32'h0, 3);
        // Misaligned LW.
        pin_res_en = 1; pin_res = 32'h0;
        run_op(32'h0002A303, 32'h101, 32'h0, 32'h0, 0);
        check("misaligned_flag_model", {31'h0, exp_mis}, {31'h0, o_misaligned});

        // Reset in the middle of a request whose ack comes 5 cycles late.
        i_insn = 32'h0002A303; i_ALU_O = 32'h300; i_mem_ack = 0;
        @(negedge clock); #1;
        check("midreq_req_before", {31'h0, o_mem_req}, 32'h1);
        @(negedge clock); #1;
        @(negedge clock); #1;
        reset = 1; #1;
        check("midreq_req_drop", {31'h0, o_mem_req}, 32'h0);
        check("midreq_addr_clr", o_mem_addr, 32'h0);
        check("midreq_wstrb_clr", {28'h0, o_mem_wstrb}, 32'h0);
        check("midreq_we_clr", {31'h0, o_mem_we}, 32'h0);
        i_insn = 32'h00B50533; i_ALU_O = 32'h55;
        @(negedge clock); #1;
        reset = 0;
        @(negedge clock); #1;
        i_mem_ack = 1; i_mem_rdata = 32'hCAFEF00D;
        @(negedge clock); #1;
        i_mem_ack = 0;
        check("late_ack_req", {31'h0, o_mem_req}, 32'h0);
        check("late_ack_stall", {31'h0, o_stall}, 32'h0);
        check("late_ack_result", o_result, 32'h55);
        // A fresh load must start cleanly from IDLE.
        run_op(32'h0002A303, 32'h400, 32'h0, 32'h13579BDF, 0);

`ifdef LSU_TIMEOUT_EN
        // No ack: abort after TO REQ cycles with o_bus_err.
        run_op(32'h0002A303, 32'h500, 32'h0, 32'h0, -1);
        // Ack on the same edge the timeout would fire: ack wins.
        pin_res_en = 1; pin_res = 32'h24681357;
        run_op(32'h0002A303, 32'h504, 32'h0, 32'h24681357, TO - 1);
`endif

        // Random instruction mix.
        for (int n = 0; n < 150; n++) begin
            sel  = $urandom_range(0, 3);
            insn = $urandom;
            insn[6:0] = (sel == 0) ? 7'h03 : (sel == 1) ? 7'h23 :
                        (sel == 2) ? 7'h33 : 7'($urandom);
            run_op(insn, $urandom, $urandom, $urandom, $urandom_range(0, MAXD));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
Memory-stage load/store unit. It consumes the X/M pipeline register outputs: instruction, ALU result used as the effective address, and regfile B used as store data. It drives a single-outstanding req/ack data-memory bus and stalls the pipeline until the access completes. It then presents the aligned, sign- or zero-extended result to the M/W latch.

Parameters:
TIMEOUT_CYCLES, 255, max cycles in REQ before abort (only with LSU_TIMEOUT_EN); counter width $clog2(TIMEOUT_CYCLES+1)

Ports:
clock  input  1  pipeline clock; all state updates on falling edge, same edge as pipeline latches
reset  input  1  reset, asynchronous, active-high
i_insn  input  32  instruction from X/M latch
i_ALU_O  input  32  effective address / ALU result from X/M latch
i_regfile_B  input  32  store data from X/M latch
o_mem_req  output  1  bus request, registered
o_mem_we  output  1  1=store, 0=load, registered
o_mem_addr  output  32  word-aligned address {addr[31:2],2'b00}, registered
o_mem_wdata  output  32  lane-replicated store data, registered
o_mem_wstrb  output  4  byte enables, registered; 0000 on loads
i_mem_ack  input  1  bus completion, one cycle
i_mem_rdata  input  32  read word, valid with ack
o_result  output  32  value to M/W latch
o_stall  output  1  freeze PC and F/D, D/X, X/M latches
o_misaligned  output  1  misaligned access flag

Behaviour:
- Decode: opcode i_insn[6:0]: 0000011=LOAD, 0100011=STORE; anything else = non-mem. funct3 i_insn[14:12]: 000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU loads only). Other funct3 on a LOAD/STORE opcode = non-mem.
- Non-mem instruction: o_result=i_ALU_O (combinational), o_stall=0, FSM stays IDLE.
- Misaligned: H/HU with addr[0]=1, or W with addr[1:0]!=0. No request issued; o_misaligned=1 combinationally; o_result=0; o_stall=0; FSM stays IDLE.
- FSM states: IDLE, REQ, DONE.
  - IDLE + aligned mem op: edge -> REQ; register req=1, we, addr, wdata, wstrb.
  - REQ: outputs held stable; i_mem_ack sampled each edge.
  - REQ + ack high at an edge: capture and extract rdata into result reg; req=0; -> DONE.
  - DONE: o_result = result reg; o_stall=0; edge -> IDLE unconditionally.
- o_stall = aligned mem op AND state != DONE. This gives minimum 2-cycle stall (IDLE, REQ) with ack on the first REQ edge; each extra REQ cycle adds 1.
- Store lanes:
  - SB: wdata={4{B[7:0]}}, wstrb=0001<<addr[1:0].
  - SH: wdata={2{B[15:0]}}, wstrb=0011 if addr[1]=0 else 1100.
  - SW: wdata=B, wstrb=1111.
  - Store result reg = i_ALU_O.
- Load extract: byte lane addr[1:0], half lane addr[1]. LB/LH sign-extend; LBU/LHU zero-extend; LW whole word.
- i_mem_ack in IDLE or DONE is ignored.
- Reset, at any time including mid-REQ: state=IDLE, o_mem_req=0, o_mem_we=0, o_mem_addr=0, o_mem_wdata=0, o_mem_wstrb=0, result reg=0, timeout counter=0. Combinational outputs follow IDLE rules. An ack arriving after reset release is ignored.

Optional Feature:
LSU_TIMEOUT_EN.
- Defined: a counter clears on IDLE->REQ and increments each REQ cycle without ack. If it reaches TIMEOUT_CYCLES: req=0, result=0, extra output o_bus_err (1 bit, reset 0) asserted for the DONE cycle, -> DONE. An ack and a timeout on the same edge: ack wins and o_bus_err stays 0.
- Not defined: no counter and no o_bus_err port; REQ waits for ack indefinitely.

Test Plan:
- Non-mem: insn=0x00B50533 (add), ALU_O=0x1234 -> o_result=0x1234, o_stall=0, o_mem_req stays 0.
- LW: insn=0x0002A303, addr=0x100, ack 1 cycle after req with rdata=0xDEADBEEF -> stall high 2 cycles, addr=0x100, wstrb=0000, DONE o_result=0xDEADBEEF.
- LB/LBU: addr=0x103, rdata=0x80FFFFFF -> LB result 0xFFFFFF80, LBU result 0x00000080.
- SB: addr=0x202, B=0x000000AB -> o_mem_addr=0x200, wdata=0xABABABAB, wstrb=0100, we=1. SH with addr=0x202 -> wstrb=1100.
- Misaligned: LW with addr=0x101 -> o_misaligned=1, o_stall=0, no req, o_result=0.
- Reset mid-REQ with ack delayed 5 cycles -> req drops immediately; later ack ignored; state IDLE. With LSU_TIMEOUT_EN and TIMEOUT_CYCLES=4, no ack -> o_bus_err=1 for one cycle after 4 REQ cycles.
